// File: rtl/note_sequencer.sv
// Score player: fetches 24-bit entries from a synchronous score ROM and drives
// the synthesizer's octave/note/duty/effect inputs for a programmed duration.
module note_sequencer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TICK_DIV = 250000
) (
  input  logic              baseclk,
  input  logic              asyncrst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              gap_en,
  input  logic [7:0]        tempo,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic [2:0]        octave,
  output logic [3:0]        note,
  output logic [3:0]        duty,
  output logic [1:0]        effect,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DECODE,
    S_PLAY
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [2:0]        octave_q, octave_d;
  logic [3:0]        note_q, note_d;
  logic [3:0]        duty_q, duty_d;
  logic [1:0]        effect_q, effect_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [7:0]        tcnt_q, tcnt_d;

  logic [1:0] ent_effect;
  logic [2:0] ent_octave;
  logic [3:0] ent_note;
  logic [3:0] ent_duty;
  logic       ent_end;
  logic [7:0] ent_len;
  logic [7:0] tempo_last;
  logic       tick;
  logic       unused_rsvd;

  assign ent_effect  = rom_data[23:22];
  assign ent_octave  = rom_data[21:19];
  assign ent_note    = rom_data[18:15];
  assign ent_duty    = rom_data[14:11];
  assign ent_end     = rom_data[10];
  assign ent_len     = rom_data[7:0];
  assign unused_rsvd = ^rom_data[9:8];

  // >= rather than == so a tempo lowered mid-note cannot strand the counter
  assign tempo_last = (tempo == 8'd0) ? 8'd0 : tempo - 8'd1;
  assign tick       = (presc_q == PRE_LAST);

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    octave_d    = octave_q;
    note_d      = note_q;
    duty_d      = duty_q;
    effect_d    = effect_q;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    tcnt_d      = tcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rom_addr_d = '0;
          state_d    = S_READ;
        end
      end
      S_READ: state_d = S_DECODE;
      S_DECODE: begin
        if (ent_end) begin
          if (loop_en && (rom_addr_q != '0)) begin
            rom_addr_d = '0;
            state_d    = S_READ;
          end else begin
            effect_d = 2'b00;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end else if (ent_len == 8'd0) begin
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          state_d    = S_READ;
        end else begin
          octave_d    = ent_octave;
          note_d      = ent_note;
          duty_d      = ent_duty;
          effect_d    = (gap_en && (ent_len == 8'd1)) ? 2'b00 : ent_effect;
          remaining_d = ent_len;
          presc_d     = '0;
          tcnt_d      = '0;
          rom_addr_d  = rom_addr_q + ADDR_W'(1);
          state_d     = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick) begin
          presc_d = '0;
          if (tcnt_q >= tempo_last) begin
            tcnt_d      = '0;
            remaining_d = remaining_q - 8'd1;
            if (gap_en && (remaining_d == 8'd1)) effect_d = 2'b00;
            if (remaining_d == 8'd0) state_d = S_READ;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end else begin
          presc_d = presc_q + PRE_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // stop aborts whatever this cycle would have done, including a finishing end marker
    if (stop) begin
      state_d    = S_IDLE;
      rom_addr_d = rom_addr_q;
      effect_d   = 2'b00;
      done_d     = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge baseclk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      octave_q    <= '0;
      note_q      <= '0;
      duty_q      <= '0;
      effect_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      presc_q     <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      octave_q    <= octave_d;
      note_q      <= note_d;
      duty_q      <= duty_d;
      effect_q    <= effect_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign octave   = octave_q;
  assign note     = note_q;
  assign duty     = duty_q;
  assign effect   = effect_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a scoreboard of expected output runs
// and ROM address changes; TICK_DIV=4, ADDR_W=2.
module tb_note_sequencer;

  localparam int unsigned ADDR_W = 2;

  logic              baseclk = 1'b0;
  logic              asyncrst_n;
  logic              start, stop, loop_en, gap_en;
  logic [7:0]        tempo;
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic [2:0]        octave;
  logic [3:0]        note, duty;
  logic [1:0]        effect;
  logic              busy, done;

  logic [23:0] rom [4];

  always #5 baseclk = ~baseclk;

  always_ff @(posedge baseclk) rom_data <= rom[rom_addr];

  note_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(4)) dut (
    .baseclk(baseclk), .asyncrst_n(asyncrst_n), .start(start), .stop(stop),
    .loop_en(loop_en), .gap_en(gap_en), .tempo(tempo), .rom_addr(rom_addr),
    .rom_data(rom_data), .octave(octave), .note(note), .duty(duty),
    .effect(effect), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [12:0] t;
    int          len;
    bit          strict;
  } run_t;

  run_t             run_q[$];
  logic [ADDR_W-1:0] addr_exp[$];
  logic [ADDR_W-1:0] addr_obs[$];
  logic [ADDR_W-1:0] last_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int bad_cnt = 0;
  int run_start = 0;
  logic busy_at_done;
  logic [1:0] eff_at_done;

  function automatic logic [23:0] mk(logic [1:0] e, logic [2:0] o, logic [3:0] n,
                                     logic [3:0] d, logic en, logic [7:0] len);
    return {e, o, n, d, en, 2'b00, len};
  endfunction

  function automatic logic [12:0] tup(logic [2:0] o, logic [3:0] n, logic [3:0] d, logic [1:0] e);
    return {o, n, d, e};
  endfunction

  function automatic logic [12:0] cur_tup();
    return {octave, note, duty, effect};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge and update the observers.
  task automatic step();
    @(negedge baseclk);
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
      eff_at_done  = effect;
    end
    if (rom_addr !== last_addr) begin
      addr_obs.push_back(rom_addr);
      last_addr = rom_addr;
    end
    if (octave === 3'd7) bad_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic exp_run(input logic [12:0] t, input int len, input bit strict);
    run_q.push_back('{t: t, len: len, strict: strict});
  endtask

  task automatic drain_runs(input string tag);
    run_t r;
    int   n;
    int   k;
    bit   found;
    k = 0;
    while (run_q.size() > 0) begin
      r = run_q.pop_front();
      if (!r.strict) begin
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
          if (cur_tup() === r.t) begin
            found = 1'b1;
            break;
          end
          step();
        end
        chk($sformatf("%s_run%0d_seen", tag, k), 32'(found), 32'd1);
      end else begin
        chk($sformatf("%s_run%0d_tuple", tag, k), 32'(cur_tup()), 32'(r.t));
      end
      run_start = cyc;
      if (r.len >= 0) begin
        n = 0;
        while (cur_tup() === r.t && n < 1000) begin
          n++;
          step();
        end
        chk($sformatf("%s_run%0d_len", tag, k), 32'(n), 32'(r.len));
      end
      k++;
    end
  endtask

  task automatic drain_addrs(input string tag);
    logic [ADDR_W-1:0] e;
    int k;
    k = 0;
    while (addr_exp.size() > 0) begin
      e = addr_exp.pop_front();
      if (addr_obs.size() > 0) chk($sformatf("%s_addr%0d", tag, k), 32'(addr_obs.pop_front()), 32'(e));
      else chk($sformatf("%s_addr%0d", tag, k), 32'hFFFF_FFFF, 32'(e));
      k++;
    end
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != base) break;
      step();
    end
  endtask

  initial begin
    int d0;
    asyncrst_n = 1'b1;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; gap_en = 1'b0; tempo = 8'd1;
    for (int i = 0; i < 4; i++) rom[i] = mk(2'b00, 3'd0, 4'd0, 4'd0, 1'b1, 8'd0);
    #2 asyncrst_n = 1'b0;
    #1;
    chk("reset_all", 32'({rom_addr, octave, note, duty, effect, busy, done}), 32'd0);
    steps(2);
    asyncrst_n = 1'b1;
    last_addr = rom_addr;
    steps(2);
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic note: len 3, tempo 2 -> 24 PLAY cycles, then READ and DECODE(end)
    rom[0] = mk(2'b01, 3'd3, 4'd9, 4'd8, 1'b0, 8'd3);
    rom[1] = mk(2'b00, 3'd0, 4'd0, 4'd0, 1'b1, 8'd0);
    tempo = 8'd2;
    d0 = done_cnt;
    exp_run(tup(3'd3, 4'd9, 4'd8, 2'b01), 26, 1'b0);
    exp_run(tup(3'd3, 4'd9, 4'd8, 2'b00), -1, 1'b1);
    pulse_start();
    chk("basic_busy_after_start", 32'(busy), 32'd1);
    drain_runs("basic");
    chk("basic_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    chk("basic_done_when", 32'(done_cyc), 32'(run_start));
    chk("basic_busy_at_done", 32'(busy_at_done), 32'd0);
    steps(3);
    chk("basic_done_single", 32'(done_cnt), 32'(d0 + 1));

    // Skip a zero-length entry; tempo 0 behaves as 1
    rom[0] = mk(2'b11, 3'd7, 4'd15, 4'd15, 1'b0, 8'd0);
    rom[1] = mk(2'b10, 3'd2, 4'd4, 4'd6, 1'b0, 8'd1);
    rom[2] = mk(2'b00, 3'd0, 4'd0, 4'd0, 1'b1, 8'd0);
    tempo = 8'd0;
    bad_cnt = 0;
    d0 = done_cnt;
    exp_run(tup(3'd2, 4'd4, 4'd6, 2'b10), 6, 1'b0);
    exp_run(tup(3'd2, 4'd4, 4'd6, 2'b00), -1, 1'b1);
    pulse_start();
    drain_runs("skip");
    chk("skip_done_when", 32'(done_cyc), 32'(run_start));
    chk("skip_never_drove", 32'(bad_cnt), 32'd0);

    // Gap: len 3 mutes its last unit; len 1 is muted from load
    rom[0] = mk(2'b10, 3'd1, 4'd3, 4'd5, 1'b0, 8'd3);
    rom[1] = mk(2'b01, 3'd6, 4'd6, 4'd6, 1'b0, 8'd1);
    rom[2] = mk(2'b00, 3'd0, 4'd0, 4'd0, 1'b1, 8'd0);
    tempo = 8'd1;
    gap_en = 1'b1;
    d0 = done_cnt;
    exp_run(tup(3'd1, 4'd3, 4'd5, 2'b10), 8, 1'b0);
    exp_run(tup(3'd1, 4'd3, 4'd5, 2'b00), 6, 1'b1);
    exp_run(tup(3'd6, 4'd6, 4'd6, 2'b00), -1, 1'b1);
    pulse_start();
    drain_runs("gap");
    wait_done(d0);
    chk("gap_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    chk("gap_done_when", 32'(done_cyc), 32'(run_start + 6));
    gap_en = 1'b0;

    // Loop over a 2-note score, then stop mid-PLAY
    rom[0] = mk(2'b01, 3'd1, 4'd1, 4'd1, 1'b0, 8'd1);
    rom[1] = mk(2'b01, 3'd2, 4'd2, 4'd2, 1'b0, 8'd1);
    rom[2] = mk(2'b00, 3'd0, 4'd0, 4'd0, 1'b1, 8'd0);
    loop_en = 1'b1;
    addr_obs.delete();
    d0 = done_cnt;
    exp_run(tup(3'd1, 4'd1, 4'd1, 2'b01), 6, 1'b0);
    exp_run(tup(3'd2, 4'd2, 4'd2, 2'b01), 8, 1'b1);
    exp_run(tup(3'd1, 4'd1, 4'd1, 2'b01), 6, 1'b1);
    exp_run(tup(3'd2, 4'd2, 4'd2, 2'b01), 8, 1'b1);
    addr_exp.push_back(2'd0); addr_exp.push_back(2'd1); addr_exp.push_back(2'd2);
    addr_exp.push_back(2'd0); addr_exp.push_back(2'd1);
    pulse_start();
    drain_runs("loop");
    drain_addrs("loop");
    chk("loop_no_done", 32'(done_cnt), 32'(d0));
    steps(2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_effect", 32'(effect), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_octave_hold", 32'(octave), 32'd1);
    steps(5);
    chk("stop_no_done", 32'(done_cnt), 32'(d0));

    // start and stop together while IDLE: stays IDLE
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("collide_busy", 32'(busy), 32'd0);
    steps(3);
    chk("collide_busy_later", 32'(busy), 32'd0);
    chk("collide_addr_hold", 32'(rom_addr), 32'd1);

    // End marker at address 0 terminates even with loop_en
    rom[0] = mk(2'b00, 3'd0, 4'd0, 4'd0, 1'b1, 8'd0);
    d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    chk("end0_done_cnt", 32'(done_cnt), 32'(d0 + 1));
    chk("end0_busy_at_done", 32'(busy_at_done), 32'd0);
    chk("end0_eff_at_done", 32'(eff_at_done), 32'd0);
    steps(10);
    chk("end0_stays_idle", 32'(done_cnt), 32'(d0 + 1));
    chk("end0_busy", 32'(busy), 32'd0);
    loop_en = 1'b0;

    // Address wrap 3 -> 0 with four non-end entries, then reset mid-note
    for (int i = 0; i < 4; i++) rom[i] = mk(2'b01, 3'(i + 1), 4'(i + 1), 4'(i + 1), 1'b0, 8'd1);
    addr_obs.delete();
    addr_exp.push_back(2'd1); addr_exp.push_back(2'd2); addr_exp.push_back(2'd3);
    addr_exp.push_back(2'd0); addr_exp.push_back(2'd1);
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      if (addr_obs.size() >= 5) break;
      step();
    end
    chk("wrap_replay_tuple", 32'(cur_tup()), 32'(tup(3'd1, 4'd1, 4'd1, 2'b01)));
    drain_addrs("wrap");
    step();
    #2 asyncrst_n = 1'b0;
    #1;
    chk("midnote_reset_all", 32'({rom_addr, octave, note, duty, effect, busy, done}), 32'd0);
    step();
    asyncrst_n = 1'b1;
    steps(3);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_addr", 32'(rom_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
